// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and retry supervisor
//
// Purpose: pulses the PLL reset, waits for a qualified lock, holds downstream
// logic in reset until lock has been stable, retries on lock timeout and
// reports failure once retries are exhausted.
//
// Ports:
//   refclk      - sole clock
//   rst         - synchronous active-high reset
//   locked      - PLL lock indicator (asynchronous, synchronized internally)
//   relock_req  - single-cycle request to rerun the PLL reset sequence (RUN/FAILED only)
//   pll_rst     - PLL reset output
//   sys_rst     - downstream active-high reset
//   ready       - PLL locked and stable
//   fail        - retries exhausted
//   retry_count - retries used in the current acquisition
//   loss_count  - saturating loss-of-lock count
//
// Optional feature: define PLL_SUP_LOSS_COUNT_EN to build the loss-of-lock
// counter; otherwise loss_count is tied to zero.

module pll_lock_supervisor #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_count,
   output logic [7:0] loss_count
);

   localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN,
      FAILED
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [1:0]    sync_q;
   logic          locked_s;

   assign locked_s = sync_q[1];

   // cnt holds the index of the current cycle within the state, so the
   // "last cycle" compares below are parameter minus one.
   always_comb begin
      state_n = state;
      case (state)
         RESET_PLL: if (cnt == RST_LAST) state_n = WAIT_LOCK;
         WAIT_LOCK: begin
            if (locked_s)
               state_n = STABILIZE;
            else if (cnt == TMO_LAST)
               state_n = (retry_count == RETRY_LIM) ? FAILED : RESET_PLL;
         end
         STABILIZE: begin
            if (!locked_s)
               state_n = WAIT_LOCK;
            else if (cnt == STB_LAST)
               state_n = RUN;
         end
         RUN:       if (!locked_s || relock_req) state_n = RESET_PLL;
         FAILED:    if (relock_req) state_n = RESET_PLL;
         default:   state_n = RESET_PLL;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge
   // as the state register and are themselves flops.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= RESET_PLL;
         cnt         <= '0;
         sync_q      <= '0;
         retry_count <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         fail        <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], locked};
         state  <= state_n;

         if (state_n != state)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + CW'(1);

         // A timeout retry only happens when retry_count < MAX_RETRIES, so
         // the increment cannot wrap.
         if (state == WAIT_LOCK && state_n == RESET_PLL)
            retry_count <= retry_count + 4'd1;
         else if (state_n == RUN || (state == FAILED && state_n == RESET_PLL))
            retry_count <= '0;

         pll_rst <= (state_n == RESET_PLL);
         sys_rst <= (state_n != RUN);
         ready   <= (state_n == RUN);
         fail    <= (state_n == FAILED);
      end
   end

`ifdef PLL_SUP_LOSS_COUNT_EN
   // Only lock loss counts; a relock_req in the same cycle is still one loss.
   always_ff @(posedge refclk) begin
      if (rst)
         loss_count <= '0;
      else if (state == RUN && !locked_s && loss_count != 8'hFF)
         loss_count <= loss_count + 8'd1;
   end
`else
   assign loss_count = 8'd0;
`endif

endmodule
